arcade_dl_ctrl: RTL
===================

ARCADE_DL_CTRL -- requirements
Module: arcade_dl_ctrl

Interface
REQ-001 Parameter: ROM_AW, 16, ROM address width; ROM space is 2^ROM_AW bytes.
REQ-002 Parameter: HOLD_CYCLES, 1024, core-reset hold length after download ends, range 1..65535.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  download in progress.
REQ-006 ioctl_wr  in  1  one-cycle write strobe.
REQ-007 ioctl_addr  in  25  write byte address.
REQ-008 ioctl_dout  in  8  write data.
REQ-009 ioctl_index  in  8  target selector: 0 ROM, 1 game id, 254 DIP bank.
REQ-010 rom_addr  out  ROM_AW  registered ROM write address.
REQ-011 rom_data  out  8  registered ROM write data.
REQ-012 rom_wr  out  1  one-cycle ROM write pulse.
REQ-013 game_id  out  8  selected game number.
REQ-014 sw_bus  out  64  DIP bank; byte n at bits [8n+7:8n].
REQ-015 core_reset  out  1  active-high reset to the game core.
REQ-016 rom_ovf  out  1  sticky: ROM write beyond 2^ROM_AW.
REQ-017 rom_sum  out  16  additive checksum of accepted ROM bytes.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and HOLD.
REQ-019 IDLE -> LOAD on a rising edge of ioctl_download, detected by comparison with a registered copy.
REQ-020 LOAD -> HOLD on a falling edge of ioctl_download; the hold counter loads HOLD_CYCLES-1.
REQ-021 In HOLD the counter SHALL decrement once per cycle; HOLD -> IDLE in the cycle the counter equals 0.
REQ-022 A rising edge of ioctl_download in HOLD SHALL go to LOAD and abandon the count.
REQ-023 core_reset SHALL be 1 in LOAD and HOLD and 0 in IDLE, decoded from a registered state.
REQ-024 Entering LOAD SHALL clear rom_ovf and rom_sum in the same edge.
REQ-025 A ROM write occurs when ioctl_wr=1, index=0, state=LOAD and ioctl_addr[24:ROM_AW]=0.
- On a ROM write, rom_wr pulses one cycle later (latency 1).
- rom_addr and rom_data SHALL carry ioctl_addr[ROM_AW-1:0] and ioctl_dout in that same cycle.
REQ-026 ioctl_wr=1, index=0, state=LOAD and nonzero ioctl_addr[24:ROM_AW] SHALL set rom_ovf without pulsing rom_wr.
REQ-027 ioctl_wr=1 with index=1 SHALL load game_id from ioctl_dout in any state; the last write wins.
REQ-028 ioctl_wr=1 with index=254 and ioctl_addr[24:3]=0 SHALL load sw_bus byte ioctl_addr[2:0] in any state.
REQ-029 All other ioctl_wr events SHALL be ignored, including index 0 outside LOAD.
REQ-030 A write strobe in the same cycle as the LOAD-entry edge SHALL be processed under the LOAD rules.
REQ-031 rom_wr SHALL never be high for two consecutive cycles unless ioctl_wr was high for two consecutive cycles.

Reset
REQ-032 Asserting reset_n=0 SHALL force state HOLD with counter HOLD_CYCLES-1.
- core_reset=1.
- rom_wr=0, rom_addr=0, rom_data=0.
- game_id=0, sw_bus=0xFFFF_FFFF_FFFF_FFFF.
- rom_ovf=0, rom_sum=0.
REQ-033 After reset_n rises the core SHALL stay in reset for exactly HOLD_CYCLES cycles, then the FSM enters IDLE.
REQ-034 Reset asserted mid-download SHALL abort LOAD immediately; ROM writes already issued are not retracted.

Configuration
REQ-035 With DL_CHECKSUM_EN defined, each ROM write SHALL add zero-extended rom_data to rom_sum, modulo 2^16, in the cycle rom_wr is high.
REQ-036 With DL_CHECKSUM_EN undefined, rom_sum SHALL be constant 0 and the checksum adder SHALL not be synthesised.

Verification
REQ-037 Release reset with HOLD_CYCLES=4 -> core_reset high for exactly 4 cycles after reset_n rises, then 0.
REQ-038 Download index 0 with bytes 0x11,0x22,0x33 at addresses 0..2 -> three rom_wr pulses, each 1 cycle after its strobe, with the matching address and data; rom_sum=0x0066 with DL_CHECKSUM_EN, 0 without.
REQ-039 Index-0 write to address 0x10000 (ROM_AW=16) -> no rom_wr and rom_ovf=1; the next download start clears rom_ovf to 0.
REQ-040 Index 254 writes of 0xA5 at address 2 and 0x5A at address 8 -> sw_bus[23:16]=0xA5; the address-8 write is ignored and all other bytes stay 0xFF.
REQ-041 Index 1 writes of 0x0C then 0x05 -> game_id=0x05.
REQ-042 Download fall, then a new rise 2 cycles into HOLD -> state LOAD, core_reset stays 1 throughout, and writes are accepted again.

Source files
------------

// File: rtl/arcade_dl_ctrl_if.sv
// Download port bundle: host-side ioctl strobes in, registered ROM write port out.
// The controller takes the slave view; the host/loader takes the master view.
interface arcade_dl_ctrl_if #(
    parameter int ROM_AW = 16
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  rom_addr, rom_data, rom_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output rom_addr, rom_data, rom_wr
    );
endinterface

// File: rtl/arcade_dl_ctrl.sv
// Arcade ROM/DIP download controller with core-reset hold sequencing.
// Optional ROM checksum: define DL_CHECKSUM_EN to build the rom_sum adder.
module arcade_dl_ctrl #(
    parameter int ROM_AW      = 16,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_dl_ctrl_if.slave       io,
    output logic [7:0]            game_id,
    output logic [63:0]           sw_bus,
    output logic                  core_reset,
    output logic                  rom_ovf,
    output logic [15:0]           rom_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              dl_q;

    logic              rom_wr_q, rom_wr_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_data_q, rom_data_d;
    logic [7:0]        game_id_q, game_id_d;
    logic [63:0]       sw_q, sw_d;
    logic              ovf_q, ovf_d;

    logic              rise;
    logic              entry;
    logic              in_load;
    logic              hi_zero;
    logic              rom_sel;
    logic              dip_hit;

    assign rise    = io.ioctl_download & ~dl_q;
    assign entry   = rise & (state_q != LOAD);
    // A strobe on the entry edge already obeys the LOAD rules.
    assign in_load = (state_q == LOAD) | rise;
    assign hi_zero = ((io.ioctl_addr >> ROM_AW) == 25'd0);
    assign rom_sel = io.ioctl_wr & (io.ioctl_index == 8'd0) & in_load;
    assign dip_hit = io.ioctl_wr & (io.ioctl_index == 8'd254)
                   & (io.ioctl_addr[24:3] == 22'd0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_INIT;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dl_q    <= io.ioctl_download;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) state_d = LOAD;
            end
            LOAD: begin
                if (!io.ioctl_download) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (rise) begin
                    state_d = LOAD;
                end else if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = HOLD_INIT;
            end
        endcase
    end

    always_comb begin
        rom_wr_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        game_id_d  = game_id_q;
        sw_d       = sw_q;
        ovf_d      = entry ? 1'b0 : ovf_q;
        if (rom_sel) begin
            if (hi_zero) begin
                rom_wr_d   = 1'b1;
                rom_addr_d = io.ioctl_addr[ROM_AW-1:0];
                rom_data_d = io.ioctl_dout;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (io.ioctl_wr && io.ioctl_index == 8'd1) begin
            game_id_d = io.ioctl_dout;
        end
        if (dip_hit) begin
            sw_d[{io.ioctl_addr[2:0], 3'b000} +: 8] = io.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_wr_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= 8'h00;
            game_id_q  <= 8'h00;
            sw_q       <= {64{1'b1}};
            ovf_q      <= 1'b0;
        end else begin
            rom_wr_q   <= rom_wr_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            game_id_q  <= game_id_d;
            sw_q       <= sw_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (entry) begin
            sum_d = 16'h0000;
        end else if (rom_wr_q) begin
            sum_d = sum_q + {8'h00, rom_data_q};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign rom_sum = sum_q;
`else
    assign rom_sum = 16'h0000;
`endif

    assign core_reset  = (state_q != IDLE);
    assign io.rom_wr   = rom_wr_q;
    assign io.rom_addr = rom_addr_q;
    assign io.rom_data = rom_data_q;
    assign game_id     = game_id_q;
    assign sw_bus      = sw_q;
    assign rom_ovf     = ovf_q;

endmodule
